// File: rtl/aha_dbg_pkg.sv
// Shared encodings for the UART-to-AHB debug master: FSM states, command
// opcodes, response status bytes and the fixed AHB-Lite attribute values.
package aha_dbg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_GET_ADDR  = 3'd1;
  localparam state_t ST_GET_DATA  = 3'd2;
  localparam state_t ST_ADDR_PH   = 3'd3;
  localparam state_t ST_DATA_PH   = 3'd4;
  localparam state_t ST_RESP_STAT = 3'd5;
  localparam state_t ST_RESP_DATA = 3'd6;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [7:0] STAT_OK     = 8'hA5;
  localparam logic [7:0] STAT_BUSERR = 8'hEE;
  localparam logic [7:0] STAT_BADCMD = 8'hE1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

endpackage

// File: rtl/aha_dbg_timeout.sv
// Inter-byte timeout: loadable down-counter that flags the idle cycle on
// which the count runs out. CYCLES = 0 disables expiry entirely.
module aha_dbg_timeout #(
  parameter int unsigned CYCLES = 65535
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam logic [15:0] LOAD_VAL = CYCLES[15:0];

  logic [15:0] cnt_q, cnt_d;

  // Reload on every accepted byte, otherwise count down while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (count_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= 16'd0;
    else          cnt_q <= cnt_d;
  end

  // Terminal count: the CYCLES-th consecutive idle cycle after a byte.
  assign expire_o = (CYCLES != 32'd0) && count_i && !load_i && (cnt_q == 16'd1);

endmodule

// File: rtl/aha_uart_ahb_debug_master.sv
// Host debug bridge: parses write/read command frames from the UART byte
// stream, issues one single-word AHB-Lite transfer, streams back a status
// byte and, for successful reads, the four read-data bytes LSB first.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | waiting for an opcode byte
// GET_ADDR     | collecting address bytes A0..A3
// GET_DATA     | collecting write-data bytes D0..D3
// ADDR_PH      | NONSEQ on the bus, held until HREADY
// DATA_PH      | waiting for HREADY to complete the data phase
// RESP_STAT    | sending the status byte
// RESP_DATA    | sending read-data bytes 0..3
module aha_uart_ahb_debug_master
  import aha_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  CMD_WRITE      = OP_WRITE,
  parameter logic [7:0]  CMD_READ       = OP_READ
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  output logic        BUSY,
  output logic        CMD_ABORT
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  status_q, status_d;
  logic        is_write_q, is_write_d;
  logic        abort_q, abort_d;
  logic        rx_take, in_rx_frame, tmo_expire;
  logic        unused_hresp;

  assign unused_hresp = HRESP[1];

  assign RX_READY    = (state_q == ST_IDLE) || (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign rx_take     = RX_VALID && RX_READY;
  assign in_rx_frame = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

  assign HTRANS    = (state_q == ST_ADDR_PH) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE    = (state_q == ST_ADDR_PH) && is_write_q;
  assign HADDR     = haddr_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;

  assign TX_VALID  = (state_q == ST_RESP_STAT) || (state_q == ST_RESP_DATA);
  assign TX_DATA   = (state_q == ST_RESP_STAT) ? status_q :
                     (state_q == ST_RESP_DATA) ? rdata_q[7:0] : 8'h00;
  assign BUSY      = (state_q != ST_IDLE);
  assign CMD_ABORT = abort_q;

  aha_dbg_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (HCLK),
    .rst_n_i  (HRESETn),
    .load_i   (rx_take),
    .count_i  (in_rx_frame && !rx_take),
    .expire_o (tmo_expire)
  );

  // Frame parsing, bus sequencing and response generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    haddr_d    = haddr_q;
    hwdata_d   = hwdata_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    is_write_d = is_write_q;
    abort_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_take) begin
          if ((RX_DATA == CMD_WRITE) || (RX_DATA == CMD_READ)) begin
            is_write_d = (RX_DATA == CMD_WRITE);
            cnt_d      = 2'd0;
            state_d    = ST_GET_ADDR;
          end else begin
            status_d = STAT_BADCMD;
            state_d  = ST_RESP_STAT;
          end
        end
      end
      ST_GET_ADDR, ST_GET_DATA: begin
        if (rx_take) begin
          // Little-endian: first byte ends up in bits [7:0].
          shreg_d = {RX_DATA, shreg_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (state_q == ST_GET_ADDR) begin
              haddr_d = {shreg_d[31:2], 2'b00};
              state_d = is_write_q ? ST_GET_DATA : ST_ADDR_PH;
            end else begin
              hwdata_d = shreg_d;
              state_d  = ST_ADDR_PH;
            end
          end
        end else if (tmo_expire) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_PH: begin
        if (HREADY) state_d = ST_DATA_PH;
      end
      ST_DATA_PH: begin
        if (HREADY) begin
          state_d = ST_RESP_STAT;
          if (HRESP[0]) begin
            status_d = STAT_BUSERR;
          end else begin
            status_d = STAT_OK;
            if (!is_write_q) rdata_d = HRDATA;
          end
        end
      end
      ST_RESP_STAT: begin
        if (TX_READY) begin
          if (!is_write_q && (status_q == STAT_OK)) begin
            cnt_d   = 2'd0;
            state_d = ST_RESP_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESP_DATA: begin
        if (TX_READY) begin
          rdata_d = {8'h00, rdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      shreg_q    <= 32'd0;
      haddr_q    <= 32'd0;
      hwdata_q   <= 32'd0;
      rdata_q    <= 32'd0;
      status_q   <= 8'd0;
      is_write_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      haddr_q    <= haddr_d;
      hwdata_q   <= hwdata_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      is_write_q <= is_write_d;
      abort_q    <= abort_d;
    end
  end

endmodule

// File: tb/tb_aha_uart_ahb_debug_master.sv
// Directed bench for the UART-to-AHB debug master. Inputs change on the
// falling edge; outputs are checked on the falling edge.
module tb_aha_uart_ahb_debug_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic [1:0]  HRESP = 2'b00;
  logic        BUSY;
  logic        CMD_ABORT;

  int errors = 0;
  int checks = 0;
  int nonseq_cnt = 0;
  int snap;

  aha_uart_ahb_debug_master #(.TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .BUSY(BUSY), .CMD_ABORT(CMD_ABORT)
  );

  always #5 HCLK = ~HCLK;

  // Count completed address phases seen on the bus.
  always @(negedge HCLK) begin
    if (HRESETn && (HTRANS == 2'b10) && HREADY) nonseq_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    while (!RX_READY && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    check("rx_accept_wait", 32'(n < 50), 32'd1);
    @(negedge HCLK);
    RX_VALID = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] exp, input string tag);
    int n = 0;
    TX_READY = 1'b1;
    while (!TX_VALID && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    check({tag, "_wait"}, 32'(n < 100), 32'd1);
    check(tag, {24'h0, TX_DATA}, {24'h0, exp});
    @(negedge HCLK);
    TX_READY = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge HCLK);
    check("rst_htrans", {30'h0, HTRANS}, 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", {31'h0, HWRITE}, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_txvalid", {31'h0, TX_VALID}, 32'h0);
    check("rst_txdata", {24'h0, TX_DATA}, 32'h0);
    check("rst_abort", {31'h0, CMD_ABORT}, 32'h0);
    check("rst_rxready", {31'h0, RX_READY}, 32'h1);
    check("rst_busy", {31'h0, BUSY}, 32'h0);
    check("const_attr", {18'h0, HSIZE, HBURST, HPROT, HMASTLOCK}, {18'h0, 3'b010, 3'b000, 4'b0011, 1'b0});
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Word write
    snap = nonseq_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    check("wr_busy_rx", {31'h0, BUSY}, 32'h1);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    check("wr_htrans", {30'h0, HTRANS}, 32'h2);
    check("wr_haddr", HADDR, 32'h4000_0000);
    check("wr_hwrite", {31'h0, HWRITE}, 32'h1);
    check("wr_rx_bp", {31'h0, RX_READY}, 32'h0);
    @(negedge HCLK);
    check("wr_dph_htrans", {30'h0, HTRANS}, 32'h0);
    check("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    recv_byte(8'hA5, "wr_status");
    check("wr_nonseq", nonseq_cnt - snap, 32'd1);
    check("wr_idle", {31'h0, BUSY}, 32'h0);

    // Word read with three wait states
    send_byte(8'h02); send_byte(8'h04); send_byte(8'h10); send_byte(8'h00); send_byte(8'h20);
    check("rd_htrans", {30'h0, HTRANS}, 32'h2);
    check("rd_haddr", HADDR, 32'h2000_1004);
    check("rd_hwrite", {31'h0, HWRITE}, 32'h0);
    @(negedge HCLK);
    HREADY = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      check("rd_ws_idle", {30'h0, HTRANS}, 32'h0);
      check("rd_ws_notx", {31'h0, TX_VALID}, 32'h0);
    end
    HREADY = 1'b1;
    HRDATA = 32'h1234_5678;
    recv_byte(8'hA5, "rd_status");
    HRDATA = 32'h0;
    recv_byte(8'h78, "rd_b0");
    recv_byte(8'h56, "rd_b1");
    recv_byte(8'h34, "rd_b2");
    recv_byte(8'h12, "rd_b3");
    check("rd_idle", {31'h0, BUSY}, 32'h0);

    // Read with address-phase stall and two-cycle ERROR response
    send_byte(8'h02); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
    HREADY = 1'b0;
    @(negedge HCLK);
    check("err_aph_hold", {30'h0, HTRANS}, 32'h2);
    check("err_aph_addr", HADDR, 32'h3000_0008);
    HREADY = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b0; HRESP = 2'b01; HRDATA = 32'hFFFF_FFFF;
    @(negedge HCLK);
    check("err_first_idle", {30'h0, HTRANS}, 32'h0);
    HREADY = 1'b1;
    @(negedge HCLK);
    HRESP = 2'b00; HRDATA = 32'h0;
    recv_byte(8'hEE, "err_status");
    check("err_idle", {31'h0, BUSY}, 32'h0);
    repeat (3) @(negedge HCLK);
    check("err_no_data", {31'h0, TX_VALID}, 32'h0);

    // Bad opcode, then a normal write
    snap = nonseq_cnt;
    send_byte(8'h7F);
    recv_byte(8'hE1, "bad_status");
    check("bad_no_bus", nonseq_cnt - snap, 32'd0);
    check("bad_idle", {31'h0, BUSY}, 32'h0);
    send_byte(8'h01); send_byte(8'h0B); send_byte(8'h00); send_byte(8'h00); send_byte(8'h50);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("bad_wr_haddr", HADDR, 32'h5000_0008);
    @(negedge HCLK);
    check("bad_wr_hwdata", HWDATA, 32'h4433_2211);
    recv_byte(8'hA5, "bad_wr_status");

    // Inter-byte timeout after 16 idle cycles
    send_byte(8'h01); send_byte(8'h00);
    repeat (15) @(negedge HCLK);
    check("tmo_not_yet", {31'h0, CMD_ABORT}, 32'h0);
    check("tmo_busy", {31'h0, BUSY}, 32'h1);
    @(negedge HCLK);
    check("tmo_abort", {31'h0, CMD_ABORT}, 32'h1);
    check("tmo_idle", {31'h0, BUSY}, 32'h0);
    check("tmo_no_tx", {31'h0, TX_VALID}, 32'h0);
    @(negedge HCLK);
    check("tmo_pulse_end", {31'h0, CMD_ABORT}, 32'h0);
    send_byte(8'h02); send_byte(8'h0C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h60);
    check("tmo_rd_haddr", HADDR, 32'h6000_000C);
    check("tmo_rd_hwrite", {31'h0, HWRITE}, 32'h0);
    HRDATA = 32'hCAFE_F00D;
    recv_byte(8'hA5, "tmo_rd_status");
    HRDATA = 32'h0;
    recv_byte(8'h0D, "tmo_rd_b0");
    recv_byte(8'hF0, "tmo_rd_b1");
    recv_byte(8'hFE, "tmo_rd_b2");
    recv_byte(8'hCA, "tmo_rd_b3");

    // TX back-pressure, then reset during RESP_DATA
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h70);
    HRDATA = 32'h89AB_CDEF;
    recv_byte(8'hA5, "bp_status");
    HRDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      check("bp_hold_data", {24'h0, TX_DATA}, 32'hEF);
      check("bp_hold_valid", {31'h0, TX_VALID}, 32'h1);
    end
    recv_byte(8'hEF, "bp_b0");
    recv_byte(8'hCD, "bp_b1");
    check("rst2_pre_valid", {31'h0, TX_VALID}, 32'h1);
    HRESETn = 1'b0;
    #1;
    check("rst2_txvalid", {31'h0, TX_VALID}, 32'h0);
    check("rst2_htrans", {30'h0, HTRANS}, 32'h0);
    check("rst2_txdata", {24'h0, TX_DATA}, 32'h0);
    check("rst2_busy", {31'h0, BUSY}, 32'h0);
    check("rst2_haddr", HADDR, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    check("rst2_after", {31'h0, TX_VALID}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
